// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter controller: op encoding and
// the internal next-address source selector.
package pc_pkg;

  localparam logic [2:0] OP_INC    = 3'd0;
  localparam logic [2:0] OP_HOLD   = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_CALL   = 3'd4;
  localparam logic [2:0] OP_RET    = 3'd5;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_SEQ,
    SRC_TARGET,
    SRC_BRANCH,
    SRC_POP
  } addr_src_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: a small LIFO that silently ignores push-when-full
// and pop-when-empty. The top of stack is presented combinationally.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_top;
  logic             w_doPush;
  logic             w_doPop;

  assign full     = (r_count == FULL);
  assign empty    = (r_count == '0);
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty && !push;
  assign w_top    = r_count - ONE;
  assign dout     = r_stack[w_top[IW-1:0]];
  assign count    = r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_doPush) begin
      r_count <= r_count + ONE;
    end else if (w_doPop) begin
      r_count <= r_count - ONE;
    end
  end

  // Entry storage needs no reset: only slots below r_count are ever read.
  always_ff @(posedge clock) begin
    if (w_doPush) begin
      r_stack[r_count[IW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: next-address selection, the PC register,
// sticky RAS error flags and the return-address stack instance.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OFF_W      = 8,
  parameter int STEP       = 1,
  parameter int DEPTH      = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [2:0]                   op,
  input  logic                         stall,
  input  logic [WIDTH-1:0]             target,
  input  logic [OFF_W-1:0]             offset,
  input  logic                         clear_err,
  output logic [WIDTH-1:0]             address,
  output logic [$clog2(DEPTH+1)-1:0]   ras_count,
  output logic                         ras_full,
  output logic                         ras_empty,
  output logic                         overflow,
  output logic                         underflow
);

  logic [WIDTH-1:0] r_address;
  logic             r_overflow;
  logic             r_underflow;

  addr_src_e        w_src;
  logic             w_push;
  logic             w_pop;
  logic             w_setOvf;
  logic             w_setUnf;
  logic             w_clear;
  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_offExt;
  logic [WIDTH-1:0] w_branch;
  logic [WIDTH-1:0] w_popAddr;
  logic [WIDTH-1:0] w_nextAddr;
  logic             w_rasFull;
  logic             w_rasEmpty;

  assign w_seq    = r_address + WIDTH'(STEP);
  assign w_offExt = WIDTH'($signed(offset));
  assign w_branch = r_address + w_offExt;
  assign w_clear  = clear_err && !stall;

  // Decode: stall masks every op, so no push, pop or flag set can leak through.
  always_comb begin
    w_src    = SRC_HOLD;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_setOvf = 1'b0;
    w_setUnf = 1'b0;
    if (!stall) begin
      case (op)
        OP_INC:    w_src = SRC_SEQ;
        OP_JUMP:   w_src = SRC_TARGET;
        OP_BRANCH: w_src = SRC_BRANCH;
        OP_CALL: begin
          w_src    = SRC_TARGET;
          w_push   = 1'b1;
          w_setOvf = w_rasFull;
        end
        OP_RET: begin
          if (w_rasEmpty) begin
            w_src    = SRC_SEQ;
            w_setUnf = 1'b1;
          end else begin
            w_src = SRC_POP;
            w_pop = 1'b1;
          end
        end
        default:   w_src = SRC_HOLD;
      endcase
    end
  end

  always_comb begin
    w_nextAddr = r_address;
    case (w_src)
      SRC_SEQ:    w_nextAddr = w_seq;
      SRC_TARGET: w_nextAddr = target;
      SRC_BRANCH: w_nextAddr = w_branch;
      SRC_POP:    w_nextAddr = w_popAddr;
      default:    w_nextAddr = r_address;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_address <= WIDTH'(RESET_ADDR);
    end else begin
      r_address <= w_nextAddr;
    end
  end

  // A new error in the same cycle as clear_err takes priority over the clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_setOvf) begin
        r_overflow <= 1'b1;
      end else if (w_clear) begin
        r_overflow <= 1'b0;
      end
      if (w_setUnf) begin
        r_underflow <= 1'b1;
      end else if (w_clear) begin
        r_underflow <= 1'b0;
      end
    end
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_seq),
    .dout  (w_popAddr),
    .count (ras_count),
    .full  (w_rasFull),
    .empty (w_rasEmpty)
  );

  assign address   = r_address;
  assign ras_full  = w_rasFull;
  assign ras_empty = w_rasEmpty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus a randomized run
// compared against a queue-based behavioural model.
module tb_pc_ctrl;

  localparam int W     = 8;
  localparam int OW    = 8;
  localparam int STEP  = 1;
  localparam int DEPTH = 4;
  localparam int RADDR = 0;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int MASK  = (1 << W) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    op = 3'd1;
  logic          stall = 1'b0;
  logic [W-1:0]  target = '0;
  logic [OW-1:0] offset = '0;
  logic          clear_err = 1'b0;
  logic [W-1:0]  address;
  logic [CW-1:0] ras_count;
  logic          ras_full;
  logic          ras_empty;
  logic          overflow;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  int refAddr;
  int refStack[$];
  bit refOvf;
  bit refUnf;

  pc_ctrl #(
    .WIDTH      (W),
    .OFF_W      (OW),
    .STEP       (STEP),
    .DEPTH      (DEPTH),
    .RESET_ADDR (RADDR)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .op        (op),
    .stall     (stall),
    .target    (target),
    .offset    (offset),
    .clear_err (clear_err),
    .address   (address),
    .ras_count (ras_count),
    .ras_full  (ras_full),
    .ras_empty (ras_empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clock = ~clock;

  task automatic modelReset();
    refAddr = RADDR;
    refStack.delete();
    refOvf = 1'b0;
    refUnf = 1'b0;
  endtask

  task automatic modelStep();
    bit so;
    bit su;
    so = 1'b0;
    su = 1'b0;
    if (!stall) begin
      case (op)
        3'd0: refAddr = (refAddr + STEP) & MASK;
        3'd2: refAddr = int'(target);
        3'd3: refAddr = (refAddr + int'($signed(offset))) & MASK;
        3'd4: begin
          if (refStack.size() < DEPTH) refStack.push_back((refAddr + STEP) & MASK);
          else so = 1'b1;
          refAddr = int'(target);
        end
        3'd5: begin
          if (refStack.size() > 0) refAddr = refStack.pop_back();
          else begin
            refAddr = (refAddr + STEP) & MASK;
            su = 1'b1;
          end
        end
        default: ;
      endcase
      if (so) refOvf = 1'b1;
      else if (clear_err) refOvf = 1'b0;
      if (su) refUnf = 1'b1;
      else if (clear_err) refUnf = 1'b0;
    end
  endtask

  task automatic applyOp(input logic [2:0] o, input int tgt, input int off,
                         input bit stl, input bit clr);
    @(negedge clock);
    op        = o;
    target    = tgt[W-1:0];
    offset    = off[OW-1:0];
    stall     = stl;
    clear_err = clr;
    @(posedge clock);
    #1;
    modelStep();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    op    = 3'd1;
    #12;
    modelReset();
    checks++; if (address !== 8'h00) begin failures++; $display("FAIL reset_address got=%h exp=00", address); end
    checks++; if (ras_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", ras_full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_inc_wrap();
    for (int i = 0; i < 260; i++) begin
      applyOp(3'd0, 0, 0, 1'b0, 1'b0);
      checks++;
      if (address !== refAddr[W-1:0]) begin
        failures++;
        $display("FAIL inc_wrap step=%0d got=%h exp=%h", i, address, refAddr[W-1:0]);
      end
    end
    checks++; if (address !== 8'h04) begin failures++; $display("FAIL inc_wrap_final got=%h exp=04", address); end
  endtask

  task automatic test_branch_jump();
    applyOp(3'd2, 'h10, 0, 1'b0, 1'b0);
    checks++; if (address !== 8'h10) begin failures++; $display("FAIL jump_10 got=%h exp=10", address); end
    applyOp(3'd3, 0, 'hFE, 1'b0, 1'b0);
    checks++; if (address !== 8'h0E) begin failures++; $display("FAIL branch_neg got=%h exp=0e", address); end
    applyOp(3'd3, 0, 'h7F, 1'b0, 1'b0);
    checks++; if (address !== 8'h8D) begin failures++; $display("FAIL branch_pos got=%h exp=8d", address); end
    applyOp(3'd2, 'h40, 0, 1'b0, 1'b0);
    checks++; if (address !== 8'h40) begin failures++; $display("FAIL jump_40 got=%h exp=40", address); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops  [4] = '{3'd4, 3'd4, 3'd5, 3'd5};
    int         tgts [4] = '{'h80, 'h90, 0, 0};
    int         expA [4] = '{'h80, 'h90, 'h81, 'h21};
    int         expC [4] = '{1, 2, 1, 0};
    applyOp(3'd2, 'h20, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyOp(ops[i], tgts[i], 0, 1'b0, 1'b0);
      checks++;
      if (address !== expA[i][W-1:0] || ras_count !== expC[i][CW-1:0]) begin
        failures++;
        $display("FAIL call_ret step=%0d got addr=%h count=%0d exp addr=%h count=%0d",
                 i, address, ras_count, expA[i][W-1:0], expC[i]);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      applyOp(3'd4, 'h40 + 8 * i, 0, 1'b0, 1'b0);
      checks++;
      if (address !== refAddr[W-1:0] || ras_count !== CW'(refStack.size())) begin
        failures++;
        $display("FAIL ovf_call step=%0d got addr=%h count=%0d exp addr=%h count=%0d",
                 i, address, ras_count, refAddr[W-1:0], refStack.size());
      end
    end
    checks++; if (ras_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", ras_full); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    applyOp(3'd4, 'h68, 0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_beats_clear got=%b exp=1", overflow); end
    for (int i = 0; i < 5; i++) begin
      applyOp(3'd5, 0, 0, 1'b0, 1'b0);
      checks++;
      if (address !== refAddr[W-1:0] || ras_count !== CW'(refStack.size())) begin
        failures++;
        $display("FAIL ovf_ret step=%0d got addr=%h count=%0d exp addr=%h count=%0d",
                 i, address, ras_count, refAddr[W-1:0], refStack.size());
      end
    end
    checks++; if (address !== 8'h23) begin failures++; $display("FAIL unf_address got=%h exp=23", address); end
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_flag got=%b exp=1", underflow); end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL unf_empty got=%b exp=1", ras_empty); end
    applyOp(3'd1, 0, 0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL clear_err got ovf=%b unf=%b exp ovf=0 unf=0", overflow, underflow);
    end
  endtask

  task automatic test_stall();
    applyOp(3'd2, 'h30, 0, 1'b0, 1'b0);
    applyOp(3'd4, 'h50, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyOp(3'd4, 'h70, 0, 1'b1, 1'b0);
      checks++;
      if (address !== 8'h50 || ras_count !== 3'd1 || overflow !== 1'b0 || underflow !== 1'b0) begin
        failures++;
        $display("FAIL stall step=%0d got addr=%h count=%0d ovf=%b unf=%b exp addr=50 count=1 ovf=0 unf=0",
                 i, address, ras_count, overflow, underflow);
      end
    end
    applyOp(3'd4, 'h70, 0, 1'b0, 1'b0);
    checks++;
    if (address !== 8'h70 || ras_count !== 3'd2) begin
      failures++;
      $display("FAIL stall_release got addr=%h count=%0d exp addr=70 count=2", address, ras_count);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checks++;
    if (address !== 8'h00 || ras_count !== 3'd0 || ras_empty !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got addr=%h count=%0d empty=%b exp addr=00 count=0 empty=1",
               address, ras_count, ras_empty);
    end
    op    = 3'd1;
    stall = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    applyOp(3'd0, 0, 0, 1'b0, 1'b0);
    checks++; if (address !== 8'h01) begin failures++; $display("FAIL post_reset_inc got=%h exp=01", address); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [2:0] o;
      bit stl;
      bit clr;
      o   = 3'($urandom_range(0, 7));
      stl = ($urandom_range(0, 6) == 0);
      clr = !stl && ($urandom_range(0, 9) == 0);
      applyOp(o, int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), stl, clr);
      checks++;
      if (address !== refAddr[W-1:0] || ras_count !== CW'(refStack.size()) ||
          ras_full !== (refStack.size() == DEPTH) || ras_empty !== (refStack.size() == 0) ||
          overflow !== refOvf || underflow !== refUnf) begin
        failures++;
        $display("FAIL random step=%0d op=%0d got addr=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b exp addr=%h cnt=%0d ovf=%b unf=%b",
                 i, o, address, ras_count, ras_full, ras_empty, overflow, underflow,
                 refAddr[W-1:0], refStack.size(), refOvf, refUnf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_branch_jump();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
